// File: rtl/uop_sequencer.sv
// uop_sequencer: steps the microcode ROM, decodes 20-bit micro-ops and
// issues them to the modular arithmetic datapath over a valid/ack handshake.
// It keeps a 3-deep history of CMP results for conditional execution and
// pulses done when a RDY word is fetched or the last ROM address completes.
module uop_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic              op_valid,
  output logic [2:0]        op_opcode,
  output logic [4:0]        op_src_a,
  output logic [4:0]        op_src_b,
  output logic [4:0]        op_dst,
  input  logic              op_ack,
  input  logic              op_cmp_ne,
  output logic [2:0]        flags
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_RDY  = 3'd0,
    OP_MOV  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_MUL  = 3'd4,
    OP_CMP  = 3'd5,
    OP_NOP6 = 3'd6,
    OP_NOP7 = 3'd7
  } opcode_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [2:0]          flags_next;
  logic                valid_next;
  logic [2:0]          opcode_next;
  logic [4:0]          src_a_next, src_b_next, dst_next;

  opcode_t             w_opcode;
  logic [4:0]          w_src_a, w_src_b, w_dst;
  logic [1:0]          w_exec;
  logic                exec_ok;
  logic                is_nop;
  logic                last_addr;

  assign w_opcode  = opcode_t'(rom_data[19:17]);
  assign w_src_a   = rom_data[16:12];
  assign w_src_b   = rom_data[11:7];
  assign w_dst     = rom_data[6:2];
  assign w_exec    = rom_data[1:0];
  assign is_nop    = (w_opcode == OP_NOP6) || (w_opcode == OP_NOP7);
  assign last_addr = &rom_addr;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Conditional-execution test against the flags held during DECODE
  always_comb begin
    exec_ok = 1'b0;
    unique case (w_exec)
      2'd0: exec_ok = 1'b1;
      2'd1: exec_ok = ~flags[2];
      2'd2: exec_ok = (flags == 3'b100);
      2'd3: exec_ok = (flags == 3'b101);
      default: exec_ok = 1'b0;
    endcase
  end

  // Next-state and next-register values for the sequencer
  always_comb begin
    state_next  = state;
    addr_next   = rom_addr;
    flags_next  = flags;
    valid_next  = op_valid;
    opcode_next = op_opcode;
    src_a_next  = op_src_a;
    src_b_next  = op_src_b;
    dst_next    = op_dst;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          addr_next  = '0;
          flags_next = '0;
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: state_next = ST_DECODE;

      ST_DECODE: begin
        if (w_opcode == OP_RDY) begin
          state_next = ST_DONE;
        end else if (is_nop || !exec_ok) begin
          // Skipped word: the top address ends the program instead of wrapping
          if (last_addr) begin
            state_next = ST_DONE;
          end else begin
            addr_next  = rom_addr + 1'b1;
            state_next = ST_FETCH;
          end
        end else begin
          opcode_next = rom_data[19:17];
          src_a_next  = w_src_a;
          src_b_next  = w_src_b;
          dst_next    = w_dst;
          valid_next  = 1'b1;
          state_next  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (op_ack) begin
          valid_next = 1'b0;
          if (op_opcode == OP_CMP) begin
            flags_next = {flags[1:0], op_cmp_ne};
          end
          if (last_addr) begin
            state_next = ST_DONE;
          end else begin
            addr_next  = rom_addr + 1'b1;
            state_next = ST_FETCH;
          end
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath-facing registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      flags     <= '0;
      op_valid  <= 1'b0;
      op_opcode <= '0;
      op_src_a  <= '0;
      op_src_b  <= '0;
      op_dst    <= '0;
    end else begin
      state     <= state_next;
      rom_addr  <= addr_next;
      flags     <= flags_next;
      op_valid  <= valid_next;
      op_opcode <= opcode_next;
      op_src_a  <= src_a_next;
      op_src_b  <= src_b_next;
      op_dst    <= dst_next;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: a ROM-walking reference model predicts
// every issued micro-op (fields, flags, issue/retire cycle) and the done cycle.
module tb_uop_sequencer;

  typedef struct {
    int addr;
    int opc;
    int sa;
    int sb;
    int dst;
    int fl;
    int rise;
    int fall;
  } exp_t;

  typedef struct {
    int d;
    int ne;
  } ack_t;

  logic        clk, rst_n, start, busy, done;
  logic [5:0]  rom_addr;
  logic [19:0] rom_data;
  logic        op_valid, op_ack, op_cmp_ne;
  logic [2:0]  op_opcode, flags;
  logic [4:0]  op_src_a, op_src_b, op_dst;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_edge = 0;
  int   issues = 0;
  int   d_fixed = 0;
  bit   start_req = 0;
  bit   inject_on = 0;
  bit   left0 = 0;
  bit   wrapped = 0;

  exp_t        exp_q[$];
  ack_t        ack_q[$];
  int          ne_force[$];
  logic [19:0] rom [64];

  uop_sequencer #(.ADDR_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .op_valid  (op_valid),
    .op_opcode (op_opcode),
    .op_src_a  (op_src_a),
    .op_src_b  (op_src_b),
    .op_dst    (op_dst),
    .op_ack    (op_ack),
    .op_cmp_ne (op_cmp_ne),
    .flags     (flags)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Registered ROM: data for rom_addr appears one clock later
  initial begin
    rom_data = '0;
    forever begin
      @(posedge clk);
      rom_data <= rom[rom_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [19:0] mk(input int opc, input int sa, input int sb,
                                     input int dst, input int ex);
    return {3'(opc), 5'(sa), 5'(sb), 5'(dst), 2'(ex)};
  endfunction

  function automatic logic [19:0] rand_word();
    int r;
    int opc;
    r = int'($urandom_range(0, 39));
    if (r == 0) opc = 0;
    else if (r < 5) opc = 6 + int'($urandom_range(0, 1));
    else if (r < 16) opc = 5;
    else opc = 1 + int'($urandom_range(0, 3));
    return mk(opc, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
  endfunction

  // Reference model: walk the ROM with the program rules, timing in cycles
  // relative to the start edge, and queue expected issues plus ack plans.
  task automatic model_run(output int done_rel, output int fl_out);
    int t;
    int fl;
    int opc, ex, d, ne;
    bit cond;
    logic [19:0] w;
    t = 0;
    fl = 0;
    done_rel = -1;
    for (int a = 0; a < 64; a++) begin
      w   = rom[a];
      opc = int'(w[19:17]);
      ex  = int'(w[1:0]);
      if (opc == 0) begin
        done_rel = t + 2;
        break;
      end
      cond = (ex == 0) || (ex == 1 && fl < 4) || (ex == 2 && fl == 4) ||
             (ex == 3 && fl == 5);
      if (opc > 5 || !cond) begin
        t += 2;
      end else begin
        d  = (d_fixed > 0) ? d_fixed : int'($urandom_range(1, 4));
        ne = int'($urandom_range(0, 1));
        if (opc == 5 && ne_force.size() > 0) ne = ne_force.pop_front();
        exp_q.push_back('{a, opc, int'(w[16:12]), int'(w[11:7]), int'(w[6:2]),
                          fl, t + 2, t + 2 + d});
        ack_q.push_back('{d, ne});
        t = t + 2 + d;
        if (opc == 5) fl = ((fl * 2) % 8) + ne;
      end
    end
    if (done_rel < 0) done_rel = t;
    fl_out = fl;
  endtask

  // Stimulus driver: start pulses, datapath acks, spurious start/ack noise
  initial begin
    ack_t cur;
    int   wait_cnt;
    bit   active;
    active    = 0;
    wait_cnt  = 0;
    cur       = '{0, 0};
    start     = 0;
    op_ack    = 0;
    op_cmp_ne = 0;
    forever begin
      @(negedge clk);
      start  = 0;
      op_ack = 0;
      if (start_req) begin
        start      = 1;
        start_edge = cyc + 1;
        start_req  = 0;
      end else if (inject_on && busy && $urandom_range(0, 5) == 0) begin
        start = 1;
      end
      if (!rst_n) begin
        active = 0;
      end else begin
        if (op_valid && !active && ack_q.size() > 0) begin
          cur      = ack_q.pop_front();
          wait_cnt = cur.d;
          active   = 1;
        end
        if (active) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            op_ack    = 1;
            op_cmp_ne = cur.ne[0];
            active    = 0;
          end
        end else if (inject_on && !op_valid && $urandom_range(0, 2) == 0) begin
          op_ack    = 1;
          op_cmp_ne = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: pop and compare on every issue, check retire timing and stability
  initial begin
    exp_t cur;
    bit   tracking;
    bit   prev_valid;
    bit   stable_bad;
    tracking   = 0;
    prev_valid = 0;
    stable_bad = 0;
    cur        = '{0, 0, 0, 0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tracking   = 0;
        prev_valid = 0;
      end else begin
        if (busy) begin
          if (rom_addr != 0) left0 = 1;
          else if (left0) wrapped = 1;
        end
        if (op_valid && !prev_valid) begin
          chk("issue_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            issues++;
            tracking   = 1;
            stable_bad = 0;
            chk("issue_addr", int'(rom_addr), cur.addr);
            chk("issue_opcode", int'(op_opcode), cur.opc);
            chk("issue_src_a", int'(op_src_a), cur.sa);
            chk("issue_src_b", int'(op_src_b), cur.sb);
            chk("issue_dst", int'(op_dst), cur.dst);
            chk("issue_flags", int'(flags), cur.fl);
            chk("issue_cycle", cyc - start_edge, cur.rise);
          end
        end
        if (op_valid && tracking) begin
          if (int'(op_opcode) != cur.opc || int'(op_src_a) != cur.sa ||
              int'(op_src_b) != cur.sb || int'(op_dst) != cur.dst)
            stable_bad = 1;
        end
        if (!op_valid && prev_valid && tracking) begin
          chk("retire_cycle", cyc - start_edge, cur.fall);
          chk("op_stable", int'(stable_bad), 0);
          tracking = 0;
        end
        prev_valid = op_valid;
      end
    end
  end

  task automatic clear_rom();
    for (int a = 0; a < 64; a++) rom[a] = '0;
  endtask

  task automatic run_prog(input string nm, input bit inject);
    int dr, fl, n_exp;
    bit got;
    exp_q.delete();
    ack_q.delete();
    issues  = 0;
    left0   = 0;
    wrapped = 0;
    model_run(dr, fl);
    ne_force.delete();
    n_exp = exp_q.size();
    inject_on = inject;
    @(posedge clk);
    #1 start_req = 1;
    got = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    if (got) chk({nm, "_done_cycle"}, cyc - start_edge, dr);
    inject_on = 0;
    @(negedge clk);
    chk({nm, "_done_width"}, int'(done), 0);
    chk({nm, "_busy_after"}, int'(busy), 0);
    chk({nm, "_issue_count"}, issues, n_exp);
    chk({nm, "_leftover"}, exp_q.size(), 0);
    chk({nm, "_final_flags"}, int'(flags), fl);
    chk({nm, "_no_wrap"}, int'(wrapped), 0);
  endtask

  initial begin
    bit got;
    rst_n = 0;
    clear_rom();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(op_valid), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_fields", int'({op_opcode, op_src_a, op_src_b, op_dst}), 0);
    rst_n = 1;
    @(negedge clk);

    // MOV 1 -> 3 then RDY, ack three cycles after issue
    clear_rom();
    rom[0] = mk(1, 1, 0, 3, 0);
    rom[1] = mk(0, 0, 0, 0, 0);
    d_fixed = 3;
    run_prog("mov_rdy", 0);
    d_fixed = 0;
    chk("mov_rdy_issues", issues, 1);

    // CMP results 1,0,0 leave flags 100: only the exec=2 word issues
    clear_rom();
    for (int a = 0; a < 3; a++) rom[a] = mk(5, a, a + 1, 0, 0);
    rom[3] = mk(2, 4, 5, 6, 1);
    rom[4] = mk(3, 7, 8, 9, 2);
    rom[5] = mk(4, 10, 11, 12, 3);
    rom[6] = mk(0, 0, 0, 0, 0);
    ne_force = '{1, 0, 0};
    run_prog("cond", 0);
    chk("cond_issues", issues, 4);
    chk("cond_flags", int'(flags), 4);

    // First CMP clears the oldest flag, so exec=1 MOVs all issue
    clear_rom();
    for (int a = 0; a < 3; a++) rom[a] = mk(5, a, 9, 0, 0);
    for (int a = 3; a < 6; a++) rom[a] = mk(1, a, 0, a, 1);
    rom[6] = mk(0, 0, 0, 0, 0);
    ne_force = '{0};
    run_prog("pz_zero", 0);
    chk("pz_zero_issues", issues, 6);

    // Every address holds a MOV: program ends at the top address
    for (int a = 0; a < 64; a++) rom[a] = mk(1, a % 32, (a * 3) % 32, (a + 7) % 32, 0);
    run_prog("full_rom", 1);
    chk("full_rom_issues", issues, 64);
    chk("full_rom_end_addr", int'(rom_addr), 63);

    // Randomised programs with noise on start and ack
    for (int p = 0; p < 10; p++) begin
      for (int a = 0; a < 64; a++) rom[a] = rand_word();
      run_prog("random", bit'(p % 2));
    end

    // Reset while waiting on an issued op, then rerun from a clean state
    clear_rom();
    for (int a = 0; a < 3; a++) rom[a] = mk(5, 1, 2, 0, 0);
    for (int a = 3; a < 24; a++) rom[a] = mk(1, a, 0, a, 0);
    exp_q.delete();
    ack_q.delete();
    issues = 0;
    ne_force = '{1, 1, 1};
    begin
      int dr, fl;
      model_run(dr, fl);
    end
    ne_force.delete();
    @(posedge clk);
    #1 start_req = 1;
    got = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (issues >= 4 && op_valid) begin
        got = 1;
        break;
      end
    end
    chk("rst_wait_reached", int'(got), 1);
    chk("rst_pre_flags", int'(flags), 7);
    #2 rst_n = 0;
    #1;
    chk("async_valid", int'(op_valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_flags", int'(flags), 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    ack_q.delete();
    #2 rst_n = 1;
    @(negedge clk);
    clear_rom();
    rom[0] = mk(1, 3, 4, 5, 1);
    rom[1] = mk(2, 6, 7, 8, 2);
    rom[2] = mk(0, 0, 0, 0, 0);
    run_prog("after_rst", 0);
    chk("after_rst_issues", issues, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
